// File: rtl/audio_mixer.sv
// Time-multiplexed stereo mixer: snapshots NUM_CH sources on next_sample, accumulates one
// channel per cycle through a shared multiplier pair, then attenuates and saturates.
module audio_mixer #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 6,
  parameter int OUT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       next_sample,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_left,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_right,
  input  logic [NUM_CH*GAIN_W-1:0]   ch_gain,
  input  logic [2:0]                 master_atten,
  output logic signed [OUT_W-1:0]    out_left,
  output logic signed [OUT_W-1:0]    out_right,
  output logic                       out_valid,
  output logic                       busy,
  output logic [1:0]                 clip,
  output logic                       overrun,
  output logic [1:0]                 o_dbg_state
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = SAMPLE_W + GAIN_W + $clog2(NUM_CH) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_SCALE = 2'd2} state_t;

  state_t r_state;
  state_t w_next_state;

  logic signed [SAMPLE_W-1:0] r_snap_l [NUM_CH];
  logic signed [SAMPLE_W-1:0] r_snap_r [NUM_CH];
  logic        [GAIN_W-1:0]   r_snap_g [NUM_CH];
  logic        [2:0]          r_atten;
  logic        [IDX_W-1:0]    r_idx;
  logic signed [ACC_W-1:0]    r_acc_l;
  logic signed [ACC_W-1:0]    r_acc_r;

  logic signed [ACC_W-1:0] w_samp_l, w_samp_r, w_gain, w_prod_l, w_prod_r;
  logic signed [ACC_W-1:0] w_shift_l, w_shift_r;
  logic signed [OUT_W-1:0] w_sat_l, w_sat_r;
  logic                    w_clip_l, w_clip_r, w_last;

  // Gain is unsigned, so it is zero-extended; samples are sign-extended.
  assign w_samp_l = ACC_W'(r_snap_l[r_idx]);
  assign w_samp_r = ACC_W'(r_snap_r[r_idx]);
  assign w_gain   = ACC_W'(r_snap_g[r_idx]);
  assign w_prod_l = w_samp_l * w_gain;
  assign w_prod_r = w_samp_r * w_gain;
  assign w_last   = (r_idx == IDX_W'(NUM_CH - 1));

  // Remove the unity-gain scale, then the master attenuation; both floor toward -inf.
  assign w_shift_l = (r_acc_l >>> (GAIN_W - 1)) >>> r_atten;
  assign w_shift_r = (r_acc_r >>> (GAIN_W - 1)) >>> r_atten;

  always_comb begin
    w_clip_l = 1'b0;
    w_clip_r = 1'b0;
    w_sat_l  = w_shift_l[OUT_W-1:0];
    w_sat_r  = w_shift_r[OUT_W-1:0];
    if (w_shift_l > SAT_MAX) begin
      w_sat_l = SAT_MAX[OUT_W-1:0]; w_clip_l = 1'b1;
    end else if (w_shift_l < SAT_MIN) begin
      w_sat_l = SAT_MIN[OUT_W-1:0]; w_clip_l = 1'b1;
    end
    if (w_shift_r > SAT_MAX) begin
      w_sat_r = SAT_MAX[OUT_W-1:0]; w_clip_r = 1'b1;
    end else if (w_shift_r < SAT_MIN) begin
      w_sat_r = SAT_MIN[OUT_W-1:0]; w_clip_r = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (next_sample) w_next_state = S_ACC;
      S_ACC:   if (w_last)      w_next_state = S_SCALE;
      S_SCALE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_snap_l[i] <= '0;
        r_snap_r[i] <= '0;
        r_snap_g[i] <= '0;
      end
      r_atten   <= '0;
      r_idx     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      clip      <= 2'b00;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      clip      <= 2'b00;
      // A strobe that arrives while a mix is running is dropped, never queued.
      overrun   <= next_sample && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: if (next_sample) begin
          for (int i = 0; i < NUM_CH; i++) begin
            r_snap_l[i] <= ch_left[i*SAMPLE_W +: SAMPLE_W];
            r_snap_r[i] <= ch_right[i*SAMPLE_W +: SAMPLE_W];
            r_snap_g[i] <= ch_gain[i*GAIN_W +: GAIN_W];
          end
          r_atten <= master_atten;
          r_idx   <= '0;
          r_acc_l <= '0;
          r_acc_r <= '0;
        end
        S_ACC: begin
          r_acc_l <= r_acc_l + w_prod_l;
          r_acc_r <= r_acc_r + w_prod_r;
          r_idx   <= r_idx + IDX_W'(1);
        end
        S_SCALE: begin
          out_left  <= w_sat_l;
          out_right <= w_sat_r;
          clip      <= {w_clip_r, w_clip_l};
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer: directed scenarios plus randomized mixes checked
// against an arithmetic reference model.
module tb_audio_mixer;

  localparam int NUM_CH = 4;
  localparam int SW     = 16;
  localparam int GW     = 6;
  localparam int OW     = 16;
  localparam int RW     = 2 + 2 * OW;

  logic                  clk;
  logic                  rst;
  logic                  next_sample;
  logic [NUM_CH*SW-1:0]  ch_left, ch_right;
  logic [NUM_CH*GW-1:0]  ch_gain;
  logic [2:0]            master_atten;
  logic signed [OW-1:0]  out_left, out_right;
  logic                  out_valid, busy, overrun;
  logic [1:0]            clip;
  logic [1:0]            o_dbg_state;

  logic [SW-1:0] tl [NUM_CH];
  logic [SW-1:0] tr [NUM_CH];
  logic [GW-1:0] tg [NUM_CH];
  logic [2:0]    t_atten;

  logic [RW-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  audio_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SW), .GAIN_W(GW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .next_sample(next_sample),
    .ch_left(ch_left), .ch_right(ch_right), .ch_gain(ch_gain),
    .master_atten(master_atten),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .busy(busy), .clip(clip), .overrun(overrun), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Weighted sum with unity gain = 32, divided back down, floor-shifted, then clamped.
  function automatic logic [RW-1:0] model_mix();
    longint sl, sr;
    logic [1:0] c;
    logic [OW-1:0] ol, orr;
    sl = 0; sr = 0; c = 2'b00;
    for (int i = 0; i < NUM_CH; i++) begin
      sl += longint'($signed(tl[i])) * longint'(tg[i]);
      sr += longint'($signed(tr[i])) * longint'(tg[i]);
    end
    sl = (sl >>> (GW - 1)) >>> t_atten;
    sr = (sr >>> (GW - 1)) >>> t_atten;
    if (sl > 32767)       begin ol = 16'h7FFF; c[0] = 1'b1; end
    else if (sl < -32768) begin ol = 16'h8000; c[0] = 1'b1; end
    else                        ol = sl[OW-1:0];
    if (sr > 32767)       begin orr = 16'h7FFF; c[1] = 1'b1; end
    else if (sr < -32768) begin orr = 16'h8000; c[1] = 1'b1; end
    else                        orr = sr[OW-1:0];
    return {c, orr, ol};
  endfunction

  // ---------------- drivers ----------------
  task automatic apply();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_left[i*SW +: SW]  = tl[i];
      ch_right[i*SW +: SW] = tr[i];
      ch_gain[i*GW +: GW]  = tg[i];
    end
    master_atten = t_atten;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NUM_CH; i++) begin
      tl[i] = SW'($urandom);
      tr[i] = SW'($urandom);
      tg[i] = '0;
    end
    t_atten = 3'd0;
  endtask

  // Called just after a rising edge; returns just after the edge that sampled the strobe.
  task automatic start_mix();
    apply();
    next_sample = 1'b1;
    @(posedge clk); #1;
    next_sample = 1'b0;
  endtask

  // Records per-cycle activity for ncyc cycles (cycle n = n-th cycle after the strobe).
  task automatic observe(input int ncyc, output int lat1, output int lat2, output int nvalid,
                         output logic [RW-1:0] got1, output logic [RW-1:0] got2,
                         output logic [31:0] busy_tr, output logic [31:0] ovr_tr);
    lat1 = -1; lat2 = -1; nvalid = 0; got1 = '0; got2 = '0; busy_tr = '0; ovr_tr = '0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      busy_tr[n] = busy;
      ovr_tr[n]  = overrun;
      if (out_valid) begin
        nvalid++;
        if (lat1 < 0) begin lat1 = n; got1 = {clip, out_right, out_left}; end
        else if (lat2 < 0) begin lat2 = n; got2 = {clip, out_right, out_left}; end
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [RW+5:0] obs;
    repeat (3) @(posedge clk);
    #1;
    obs = {out_left, out_right, clip, out_valid, busy, overrun, o_dbg_state};
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, out_valid, o_dbg_state} !== 4'b0) begin
      n_fail++; $display("FAIL reset_release_idle: got %b expected 0000", {busy, out_valid, o_dbg_state});
    end
  endtask

  task automatic test_zero_gain();
    int l1, l2, nv; logic [RW-1:0] g1, g2; logic [31:0] bt, ot;
    clear_sources();
    t_atten = 3'($urandom_range(0, 7));
    start_mix();
    observe(10, l1, l2, nv, g1, g2, bt, ot);
    n_checks++;
    if (l1 !== 6) begin n_fail++; $display("FAIL zero_gain_latency: got %0d expected 6", l1); end
    n_checks++;
    if (g1 !== '0) begin n_fail++; $display("FAIL zero_gain_output: got %h expected 0", g1); end
    n_checks++;
    if (bt !== 32'h3E) begin n_fail++; $display("FAIL zero_gain_busy: got %h expected 3e", bt); end
    n_checks++;
    if (nv !== 1) begin n_fail++; $display("FAIL zero_gain_valid_count: got %0d expected 1", nv); end
  endtask

  task automatic test_unity();
    int l1, l2, nv; logic [RW-1:0] g1, g2; logic [31:0] bt, ot;
    clear_sources();
    tl[0] = 16'h1000; tr[0] = 16'hF000; tg[0] = 6'd32;
    start_mix();
    observe(8, l1, l2, nv, g1, g2, bt, ot);
    n_checks++;
    if (g1 !== {2'b00, 16'hF000, 16'h1000}) begin
      n_fail++; $display("FAIL unity_gain: got %h expected %h", g1, {2'b00, 16'hF000, 16'h1000});
    end
  endtask

  task automatic test_saturation();
    int l1, l2, nv; logic [RW-1:0] g1, g2; logic [31:0] bt, ot;
    clear_sources();
    for (int i = 0; i < 2; i++) begin tl[i] = 16'h4000; tr[i] = 16'h8000; tg[i] = 6'd32; end
    start_mix();
    observe(8, l1, l2, nv, g1, g2, bt, ot);
    n_checks++;
    if (g1 !== {2'b11, 16'h8000, 16'h7FFF}) begin
      n_fail++; $display("FAIL saturation: got %h expected %h", g1, {2'b11, 16'h8000, 16'h7FFF});
    end
  endtask

  task automatic test_gain_atten();
    int l1, l2, nv; logic [RW-1:0] g1, g2; logic [31:0] bt, ot;
    clear_sources();
    tl[0] = 16'h2000; tr[0] = 16'h0000; tg[0] = 6'd16;
    tl[1] = 16'h2000; tr[1] = 16'h0000; tg[1] = 6'd48;
    t_atten = 3'd1;
    start_mix();
    observe(8, l1, l2, nv, g1, g2, bt, ot);
    n_checks++;
    if (g1 !== {2'b00, 16'h0000, 16'h2000}) begin
      n_fail++; $display("FAIL gain_atten: got %h expected %h", g1, {2'b00, 16'h0000, 16'h2000});
    end
  endtask

  task automatic test_atten_edges();
    int l1, l2, nv; logic [RW-1:0] g1, g2; logic [31:0] bt, ot;
    clear_sources();
    tl[0] = 16'h7FFF; tr[0] = 16'h8001; tg[0] = 6'd32; t_atten = 3'd7;
    start_mix();
    observe(8, l1, l2, nv, g1, g2, bt, ot);
    n_checks++;
    if (g1 !== {2'b00, 16'hFF00, 16'h00FF}) begin
      n_fail++; $display("FAIL atten7_floor: got %h expected %h", g1, {2'b00, 16'hFF00, 16'h00FF});
    end
    clear_sources();
    tl[0] = 16'h0005; tr[0] = 16'hFFFB; tg[0] = 6'd32; t_atten = 3'd2;
    start_mix();
    observe(8, l1, l2, nv, g1, g2, bt, ot);
    n_checks++;
    if (g1 !== {2'b00, 16'hFFFE, 16'h0001}) begin
      n_fail++; $display("FAIL atten2_floor: got %h expected %h", g1, {2'b00, 16'hFFFE, 16'h0001});
    end
  endtask

  task automatic test_overrun_back_to_back();
    int l1, l2, nv; logic [RW-1:0] g1, g2, e1, e2; logic [31:0] bt, ot;
    clear_sources();
    tl[0] = 16'h1234; tr[0] = 16'h0010; tg[0] = 6'd32;
    exp_q.push_back({2'b00, 16'h0010, 16'h1234});
    exp_q.push_back({2'b00, 16'hFF00, 16'h0100});
    start_mix();
    fork
      begin
        // New inputs mid-mix must not leak into the running result.
        tl[0] = 16'h0100; tr[0] = 16'hFF00;
        apply();
        @(posedge clk); @(posedge clk); #1;
        next_sample = 1'b1;
        @(posedge clk); #1;
        next_sample = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        next_sample = 1'b1;
        @(posedge clk); #1;
        next_sample = 1'b0;
      end
      observe(14, l1, l2, nv, g1, g2, bt, ot);
    join
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    n_checks++;
    if (ot !== 32'h10) begin n_fail++; $display("FAIL overrun_pulse: got %h expected 10", ot); end
    n_checks++;
    if (nv !== 2) begin n_fail++; $display("FAIL overrun_valid_count: got %0d expected 2", nv); end
    n_checks++;
    if (l1 !== 6 || l2 !== 12) begin
      n_fail++; $display("FAIL back_to_back_latency: got %0d/%0d expected 6/12", l1, l2);
    end
    n_checks++;
    if (g1 !== e1) begin n_fail++; $display("FAIL overrun_first_result: got %h expected %h", g1, e1); end
    n_checks++;
    if (g2 !== e2) begin n_fail++; $display("FAIL back_to_back_result: got %h expected %h", g2, e2); end
    n_checks++;
    if (bt !== 32'hFBE) begin n_fail++; $display("FAIL back_to_back_busy: got %h expected fbe", bt); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_right, out_left} !== {1'b0, e2[2*OW-1:0]}) begin
      n_fail++; $display("FAIL output_hold: got %h expected %h", {out_valid, out_right, out_left}, {1'b0, e2[2*OW-1:0]});
    end
  endtask

  task automatic test_reset_mid_mix();
    int l1, l2, nv; logic [RW-1:0] g1, g2; logic [31:0] bt, ot;
    logic [RW+5:0] obs;
    clear_sources();
    tl[0] = 16'h0800; tr[0] = 16'h0400; tg[0] = 6'd32;
    start_mix();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    obs = {out_left, out_right, clip, out_valid, busy, overrun, o_dbg_state};
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_mid_mix_clear: got %h expected 0", obs); end
    observe(8, l1, l2, nv, g1, g2, bt, ot);
    n_checks++;
    if (nv !== 0) begin n_fail++; $display("FAIL reset_mid_mix_no_valid: got %0d expected 0", nv); end
    rst = 1'b1;
    @(posedge clk); #1;
    start_mix();
    observe(8, l1, l2, nv, g1, g2, bt, ot);
    n_checks++;
    if (l1 !== 6 || g1 !== {2'b00, 16'h0400, 16'h0800}) begin
      n_fail++; $display("FAIL reset_mid_mix_fresh: got lat %0d data %h expected lat 6 data %h",
                         l1, g1, {2'b00, 16'h0400, 16'h0800});
    end
  endtask

  task automatic test_random();
    int l1, l2, nv; logic [RW-1:0] g1, g2, e; logic [31:0] bt, ot;
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tl[i] = SW'($urandom);
        tr[i] = SW'($urandom);
        tg[i] = GW'($urandom_range(0, (1 << GW) - 1));
      end
      t_atten = 3'($urandom_range(0, 7));
      exp_q.push_back(model_mix());
      start_mix();
      observe(8, l1, l2, nv, g1, g2, bt, ot);
      e = exp_q.pop_front();
      n_checks++;
      if (g1 !== e || l1 !== 6) begin
        n_fail++; $display("FAIL random_mix_%0d: got lat %0d data %h expected lat 6 data %h", k, l1, g1, e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    next_sample = 1'b0;
    ch_left = '0; ch_right = '0; ch_gain = '0; master_atten = '0;
    test_reset();
    test_zero_gain();
    test_unity();
    test_saturation();
    test_gain_atten();
    test_atten_edges();
    test_overrun_back_to_back();
    test_reset_mid_mix();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
